ysyx_25040101_alu_arb: RTL

//  Shares the single combinational ALU between two requesters (r0 = EXU main issue, r1 = auxiliary

---
 rtl/ysyx_25040101_alu_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040101_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry response buffer and a saturating grant counter per requester.
module ysyx_25040101_alu_arb #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              r0_req_valid_i,
  output logic              r0_req_ready_o,
  input  logic [DATA_W-1:0] r0_srca_i,
  input  logic [DATA_W-1:0] r0_srcb_i,
  input  logic [CTRL_W-1:0] r0_ctrl_i,
  input  logic [TAG_W-1:0]  r0_tag_i,
  output logic              r0_rsp_valid_o,
  input  logic              r0_rsp_ready_i,
  output logic [DATA_W-1:0] r0_result_o,
  output logic              r0_borrow_o,
  output logic              r0_ovf_o,
  output logic              r0_err_o,
  output logic [TAG_W-1:0]  r0_tag_o,
  output logic [CNT_W-1:0]  r0_grant_cnt_o,
  input  logic              r1_req_valid_i,
  output logic              r1_req_ready_o,
  input  logic [DATA_W-1:0] r1_srca_i,
  input  logic [DATA_W-1:0] r1_srcb_i,
  input  logic [CTRL_W-1:0] r1_ctrl_i,
  input  logic [TAG_W-1:0]  r1_tag_i,
  output logic              r1_rsp_valid_o,
  input  logic              r1_rsp_ready_i,
  output logic [DATA_W-1:0] r1_result_o,
  output logic              r1_borrow_o,
  output logic              r1_ovf_o,
  output logic              r1_err_o,
  output logic [TAG_W-1:0]  r1_tag_o,
  output logic [CNT_W-1:0]  r1_grant_cnt_o,
  output logic [DATA_W-1:0] alu_srca_o,
  output logic [DATA_W-1:0] alu_srcb_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_borrow_i,
  input  logic              alu_ovf_i
);

  localparam logic [CTRL_W-1:0] CTRL_ONE = CTRL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic [DATA_W-1:0] srca [2];
  logic [DATA_W-1:0] srcb [2];
  logic [CTRL_W-1:0] ctrl [2];
  logic [TAG_W-1:0]  tag  [2];

  logic              rr_ptr_reg;
  logic              rsp_valid_reg [2];
  logic [DATA_W-1:0] result_reg    [2];
  logic              borrow_reg    [2];
  logic              ovf_reg       [2];
  logic              err_reg       [2];
  logic [TAG_W-1:0]  tag_reg       [2];
  logic [CNT_W-1:0]  cnt_reg       [2];

  logic              sel;
  logic [CTRL_W-1:0] ctrl_mux;
  logic              ctrl_err;

  assign req_valid = {r1_req_valid_i, r0_req_valid_i};
  assign rsp_ready = {r1_rsp_ready_i, r0_rsp_ready_i};
  assign srca[0] = r0_srca_i;
  assign srca[1] = r1_srca_i;
  assign srcb[0] = r0_srcb_i;
  assign srcb[1] = r1_srcb_i;
  assign ctrl[0] = r0_ctrl_i;
  assign ctrl[1] = r1_ctrl_i;
  assign tag[0]  = r0_tag_i;
  assign tag[1]  = r1_tag_i;

  // A full buffer being drained this cycle counts as free.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_valid[gi] & (~rsp_valid_reg[gi] | rsp_ready[gi]);
    end
  endgenerate

  // Grants are suppressed while reset is held so ready stays low.
  always_comb begin
    grant = 2'b00;
    if (!rst_n_i) begin
      grant = 2'b00;
    end else if (&elig) begin
      grant = rr_ptr_reg ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

  assign sel        = grant[1];
  assign ctrl_mux   = sel ? ctrl[1] : ctrl[0];
  assign alu_srca_o = sel ? srca[1] : srca[0];
  assign alu_srcb_o = sel ? srcb[1] : srcb[0];
  assign alu_ctrl_o = (|grant) ? ctrl_mux : '0;
  assign ctrl_err   = (ctrl_mux == '0) || ((ctrl_mux & (ctrl_mux - CTRL_ONE)) != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rsp_valid_reg[i] <= 1'b0;
        result_reg[i]    <= '0;
        borrow_reg[i]    <= 1'b0;
        ovf_reg[i]       <= 1'b0;
        err_reg[i]       <= 1'b0;
        tag_reg[i]       <= '0;
        cnt_reg[i]       <= '0;
      end
    end else begin
      if (|grant) begin
        rr_ptr_reg <= ~grant[1];
      end
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          // A load in the same cycle as a drain wins.
          rsp_valid_reg[i] <= 1'b1;
          result_reg[i]    <= ctrl_err ? '0 : alu_result_i;
          borrow_reg[i]    <= ctrl_err ? 1'b0 : alu_borrow_i;
          ovf_reg[i]       <= ctrl_err ? 1'b0 : alu_ovf_i;
          err_reg[i]       <= ctrl_err;
          tag_reg[i]       <= tag[i];
          if (cnt_reg[i] != '1) begin
            cnt_reg[i] <= cnt_reg[i] + CNT_ONE;
          end
        end else if (rsp_valid_reg[i] && rsp_ready[i]) begin
          rsp_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign r0_req_ready_o = grant[0];
  assign r1_req_ready_o = grant[1];
  assign r0_rsp_valid_o = rsp_valid_reg[0];
  assign r1_rsp_valid_o = rsp_valid_reg[1];
  assign r0_result_o    = result_reg[0];
  assign r1_result_o    = result_reg[1];
  assign r0_borrow_o    = borrow_reg[0];
  assign r1_borrow_o    = borrow_reg[1];
  assign r0_ovf_o       = ovf_reg[0];
  assign r1_ovf_o       = ovf_reg[1];
  assign r0_err_o       = err_reg[0];
  assign r1_err_o       = err_reg[1];
  assign r0_tag_o       = tag_reg[0];
  assign r1_tag_o       = tag_reg[1];
  assign r0_grant_cnt_o = cnt_reg[0];
  assign r1_grant_cnt_o = cnt_reg[1];

endmodule
